// File: rtl/fm_bram_1_row_packer_if.sv
// Pixel-word stream between the conv/pool datapath (master) and the FM_BRAM_1 row packer (slave).
interface fm_bram_1_row_packer_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/fm_bram_1_row_packer.sv
// Packs ROW_W/DATA_W consecutive pixel words into one FM_BRAM_1 row and writes a frame of
// num_rows rows from base_addr through port A, one single-cycle write strobe per row.
module fm_bram_1_row_packer #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 1024,
    parameter int ADDR_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     num_rows,
    fm_bram_1_row_packer_if.slave in_s,
    output logic                busy,
    output logic                done,
    output logic                bram_ena,
    output logic                bram_wea,
    output logic [ADDR_W-1:0]   bram_addra,
    output logic [ROW_W-1:0]    bram_dina
);
    localparam int WPR   = ROW_W / DATA_W;
    localparam int IDX_W = (WPR > 1) ? $clog2(WPR) : 1;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    word_idx_reg;
    logic [ADDR_W:0]     row_idx_reg;
    logic [ADDR_W:0]     num_rows_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [ROW_W-1:0]    row_buf_reg;
    logic [ROW_W-1:0]    row_full;
    logic                ena_reg;
    logic                done_reg;
    logic [ADDR_W-1:0]   addra_reg;
    logic [ROW_W-1:0]    dina_reg;
    logic [WPR-1:0]      word_we;

    logic                in_ready_c;
    logic                busy_c;
    logic                start_ok;
    logic                accept;
    logic                word_last;
    logic                row_last;

    assign word_last = (word_idx_reg == IDX_W'(WPR - 1));
    assign row_last  = (row_idx_reg == (num_rows_reg - (ADDR_W+1)'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        start_ok   = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                start_ok = start;
                if (start && (num_rows != '0)) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                accept     = in_s.in_valid;
                if (in_s.in_valid && word_last && row_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                busy_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The incoming word is merged into its lane here, so the completed row (including the
    // last word) is available in the same cycle it is accepted.
    generate
        for (genvar gi = 0; gi < WPR; gi++) begin : g_lane
            assign word_we[gi] = accept && (word_idx_reg == IDX_W'(gi));
            assign row_full[gi*DATA_W +: DATA_W] =
                word_we[gi] ? in_s.in_data : row_buf_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx_reg <= '0;
            row_idx_reg  <= '0;
            num_rows_reg <= '0;
            base_reg     <= '0;
            row_buf_reg  <= '0;
            ena_reg      <= 1'b0;
            done_reg     <= 1'b0;
            addra_reg    <= '0;
            dina_reg     <= '0;
        end else begin
            ena_reg  <= 1'b0;
            done_reg <= 1'b0;
            if (start_ok) begin
                base_reg     <= base_addr;
                num_rows_reg <= num_rows;
                word_idx_reg <= '0;
                row_idx_reg  <= '0;
                if (num_rows == '0) begin
                    done_reg <= 1'b1;
                end
            end
            if (accept) begin
                row_buf_reg <= row_full;
                if (word_last) begin
                    word_idx_reg <= '0;
                    row_idx_reg  <= row_idx_reg + (ADDR_W+1)'(1);
                    ena_reg      <= 1'b1;
                    // Address arithmetic is ADDR_W wide, so rows wrap from the top back to 0.
                    addra_reg    <= base_reg + row_idx_reg[ADDR_W-1:0];
                    dina_reg     <= row_full;
                end else begin
                    word_idx_reg <= word_idx_reg + IDX_W'(1);
                end
            end
            if (state_reg == FLUSH) begin
                done_reg <= 1'b1;
            end
        end
    end

    assign in_s.in_ready = in_ready_c;
    assign busy          = busy_c;
    assign done          = done_reg;
    assign bram_ena      = ena_reg;
    assign bram_wea      = ena_reg;
    assign bram_addra    = addra_reg;
    assign bram_dina     = dina_reg;
endmodule

// File: tb/tb_fm_bram_1_row_packer.sv
// Bench for fm_bram_1_row_packer: table of frames driven with random data and checked
// against a word-queue model, plus hand-written reset sequences.
module tb_fm_bram_1_row_packer;
    localparam int DATA_W = 32;
    localparam int ROW_W  = 1024;
    localparam int ADDR_W = 7;
    localparam int WPR    = ROW_W / DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_rows;
    logic              busy, done, bram_ena, bram_wea;
    logic [ADDR_W-1:0] bram_addra;
    logic [ROW_W-1:0]  bram_dina;

    fm_bram_1_row_packer_if #(.DATA_W(DATA_W)) s_if ();

    fm_bram_1_row_packer #(.DATA_W(DATA_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .in_s       (s_if),
        .busy       (busy),
        .done       (done),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  data;
        int                c;
    } wr_t;

    typedef struct {
        int base;
        int nrows;
        int pct;
        bit seq;
        bit glitch;
        int exp_strobes;
    } vec_t;

    logic [DATA_W-1:0] acc_q[$];
    int                acc_cyc_q[$];
    wr_t               wr_q[$];
    int                done_cnt = 0;
    int                done_cyc = 0;
    logic              done_busy = 1'b0;
    bit                busy_seen = 1'b0;
    int                start_cyc = -1;
    int                ena_wea_bad = 0;

    // Observe the DUT away from the active edge; accepts seen here happen at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_if.in_valid && s_if.in_ready) begin
                acc_q.push_back(s_if.in_data);
                acc_cyc_q.push_back(cyc);
            end
            if (bram_ena || bram_wea) wr_q.push_back('{bram_addra, bram_dina, cyc});
            if (bram_ena !== bram_wea) ena_wea_bad++;
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (busy) busy_seen = 1'b1;
            if (start && !busy) start_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < WPR; k++) begin
                if (act[k*DATA_W +: DATA_W] !== exp[k*DATA_W +: DATA_W]) begin
                    $display("FAIL %s word %0d actual=%0h required=%0h", name, k,
                             act[k*DATA_W +: DATA_W], exp[k*DATA_W +: DATA_W]);
                    break;
                end
            end
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, s_if.in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ena_wea"}, {bram_ena, bram_wea}, 0);
        chk({tag, "_addra"}, bram_addra, 0);
        chk({tag, "_dina_nz"}, |bram_dina, 0);
    endtask

    task automatic run_frame(input vec_t v);
        int d0, n, budget, nfull;
        logic [ROW_W-1:0] exp_row;
        acc_q.delete();
        acc_cyc_q.delete();
        wr_q.delete();
        busy_seen   = 1'b0;
        start_cyc   = -1;
        ena_wea_bad = 0;
        d0          = done_cnt;
        budget      = ((v.nrows * WPR * 100) / v.pct) * 2 + 50;

        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = ADDR_W'(v.base);
        num_rows  = (ADDR_W+1)'(v.nrows);
        s_if.in_valid = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        num_rows  = (ADDR_W+1)'($urandom);
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            s_if.in_valid = ($urandom_range(99) < v.pct);
            s_if.in_data  = v.seq ? DATA_W'(acc_q.size()) : DATA_W'($urandom);
            if (v.glitch && n == 40) begin
                start     = 1'b1;
                base_addr = ADDR_W'(v.base + 17);
                num_rows  = (ADDR_W+1)'(v.nrows + 2);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        s_if.in_valid = 1'b0;
        start = 1'b0;

        $display("frame base=%0d rows=%0d pct=%0d words=%0d strobes=%0d cycles=%0d",
                 v.base, v.nrows, v.pct, acc_q.size(), wr_q.size(), n);
        chk("done_seen", done_cnt - d0, 1);
        chk("strobe_count", wr_q.size(), v.exp_strobes);
        chk("words_accepted", acc_q.size(), v.nrows * WPR);
        chk("ena_eq_wea", ena_wea_bad, 0);
        chk("busy_at_done", done_busy, 0);
        if (v.nrows == 0) begin
            chk("busy_never", busy_seen, 0);
            chk("done_lat_empty", done_cyc - start_cyc, 1);
        end else if (acc_q.size() > 0) begin
            chk("done_lat", done_cyc - acc_cyc_q[acc_cyc_q.size()-1], 2);
            if (v.pct == 100)
                chk("no_bubble", acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[0] + 1, v.nrows * WPR);
            nfull = acc_q.size() / WPR;
            for (int r = 0; r < wr_q.size() && r < nfull; r++) begin
                for (int k = 0; k < WPR; k++) exp_row[k*DATA_W +: DATA_W] = acc_q[r*WPR + k];
                chk("row_addr", wr_q[r].addr, (v.base + r) % (1 << ADDR_W));
                chk_row("row_data", wr_q[r].data, exp_row);
                chk("write_lat", wr_q[r].c - acc_cyc_q[r*WPR + WPR - 1], 1);
            end
            if (v.seq && wr_q.size() > 0) begin
                chk("dina_lo", wr_q[0].data[31:0], 0);
                chk("dina_hi", wr_q[0].data[ROW_W-1 -: DATA_W], 'h1F);
            end
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{base: 0,   nrows: 1,   pct: 100, seq: 1, glitch: 0, exp_strobes: 1};
        vecs[1] = '{base: 126, nrows: 4,   pct: 100, seq: 0, glitch: 0, exp_strobes: 4};
        vecs[2] = '{base: 10,  nrows: 3,   pct: 50,  seq: 0, glitch: 0, exp_strobes: 3};
        vecs[3] = '{base: 40,  nrows: 3,   pct: 70,  seq: 0, glitch: 1, exp_strobes: 3};
        vecs[4] = '{base: 0,   nrows: 0,   pct: 100, seq: 0, glitch: 0, exp_strobes: 0};
        vecs[5] = '{base: 0,   nrows: 128, pct: 100, seq: 0, glitch: 0, exp_strobes: 128};
        vecs[6] = '{base: 100, nrows: 5,   pct: 30,  seq: 0, glitch: 0, exp_strobes: 5};

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_rows = '0;
        s_if.in_valid = 1'b0;
        s_if.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Abandon a frame after 10 words with an asynchronous reset mid-cycle.
        wr_q.delete();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 7'd5; num_rows = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_if.in_valid = 1'b1;
            s_if.in_data  = $urandom;
            @(posedge clk); #1;
        end
        s_if.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("mid-frame reset after 10 words");
        chk_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("no_stray_write", wr_q.size(), 0);

        foreach (vecs[i]) run_frame(vecs[i]);

        repeat (5) @(posedge clk);
        #1;
        chk("no_late_strobe", bram_ena, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end
endmodule
